axi_slave_write_ctrl: RTL
=========================

Name: axi_slave_write_ctrl

Overview:
- AXI write-side slave that consumes the tbbfm write address (AW), write data (W) and write response (B) channels driven by the bench.
- Accepts one burst at a time, writes beats into an internal byte-strobed word memory and returns one B response per burst.
- Exposes a registered debug read port so the bench can check memory contents.

Parameters:
- WIDTH, 32, data/address width in bits; ID and LEN fields are WIDTH/8 bits wide.
- SIZE, 3, width of AWSIZE; AWBURST and BRESP are SIZE-1 bits wide.
- MEM_DEPTH, 256, number of WIDTH-bit words (power of 2); valid byte range is 0 to MEM_DEPTH*WIDTH/8-1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- AWVALID  in  1  address valid
- AWREADY  out  1  address ready
- AWADDR  in  WIDTH  burst start byte address
- AWID  in  WIDTH/8  transaction ID
- AWLEN  in  WIDTH/8  beats minus 1
- AWSIZE  in  SIZE  bytes per beat = 2^AWSIZE
- AWBURST  in  SIZE-1  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- WVALID  in  1  data valid
- WREADY  out  1  data ready
- WDATA  in  WIDTH  write data
- WSTRB  in  WIDTH/8  byte lane enables
- WLAST  in  1  final beat marker
- WID  in  WIDTH/8  data ID (checked only under AXI_WID_CHECK_EN)
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- BID  out  WIDTH/8  echoes latched AWID
- BRESP  out  SIZE-1  00 OKAY, 10 SLVERR, 11 DECERR
- dbg_addr  in  log2(MEM_DEPTH)  debug word index
- dbg_rdata  out  WIDTH  mem[dbg_addr], one-cycle registered

Behaviour:
- Reset: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, dbg_rdata=0, FSM=IDLE, beat counter=0, error flags cleared. Memory is not cleared.
- Reset mid-burst aborts the burst. No B response is issued, and memory writes already made remain.
- FSM IDLE: AWREADY=1, registered, so it is first high the cycle after reset deasserts.
  - On AWVALID&&AWREADY, latch AWADDR/AWID/AWLEN/AWSIZE/AWBURST, clear beat count, go to DATA.
  - AWREADY=0 the next cycle.
- FSM DATA: WREADY=1.
  - Each WVALID&&WREADY writes WDATA into word addr[log2(MEM_DEPTH)+1:2], byte lanes gated by WSTRB.
  - The write is visible on dbg_rdata two cycles after the handshake edge (memory write, then registered read).
  - After each beat, the address generator advances the address and the counter increments.
  - On beat count==AWLEN: WREADY=0 next cycle, go to RESP.
- FSM RESP: BVALID=1 with BID and BRESP held stable until BVALID&&BREADY, then go to IDLE.
  - If BREADY is already high, BVALID is high for exactly one cycle.
- Minimum burst cycle count: 1 (AW) + (AWLEN+1) (W) + 1 (B).
- Address generation:
  - FIXED: address constant.
  - INCR: address += 2^AWSIZE.
  - WRAP: wrap boundary = (AWLEN+1)*2^AWSIZE, aligned down; address wraps within that window.
  - Address arithmetic is WIDTH-bit unsigned and rolls over mod 2^WIDTH.
- SLVERR conditions (sticky per burst; all beats still accepted, no beat written):
  - AWBURST=11.
  - 2^AWSIZE > WIDTH/8.
  - WRAP with AWLEN not in {1,3,7,15}.
  - WRAP with unaligned AWADDR.
- WLAST mismatch: WLAST high before the final beat, or low on the final beat, sets SLVERR. Beats are still written, and the burst terminates on the count, never on WLAST.
- DECERR: any beat address outside the valid range. That beat's write is suppressed; other beats are written normally.
- BRESP priority: DECERR > SLVERR > OKAY.
- W data arriving while in IDLE or RESP is not accepted (WREADY=0).

Optional Feature:
- Macro: AXI_WID_CHECK_EN.
- Defined: a beat with WID != latched AWID is accepted but not written, and sets SLVERR.
- Not defined: WID is ignored entirely.

Decomposition:
- Package axi_pkg holds:
  - Burst enum: FIXED/INCR/WRAP/RSVD.
  - Response enum: OKAY/EXOKAY/SLVERR/DECERR.
  - FSM state enum: IDLE/DATA/RESP.
  - Default WIDTH/SIZE constants.
- One sub-module, axi_burst_addr_gen: purely combinational next-address computation plus the WRAP/size legality check, taking current address, AWSIZE, AWLEN and AWBURST.

Test Plan:
- INCR, AWADDR=0x10, AWLEN=3, AWSIZE=2, WDATA 0xA0..0xA3, WSTRB=0xF -> words 4..7 = 0xA0..0xA3; BRESP=00, BID=AWID.
- WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=2 -> beats written to 0x38, 0x3C, 0x30, 0x34; BRESP=00.
- FIXED, AWADDR=0x8, AWLEN=1, beat1 0x11223344/WSTRB=0xF, beat2 0xFFFFFFFF/WSTRB=0x1 -> word 2 = 0x112233FF; BRESP=00.
- INCR, AWADDR=0x3FC, AWLEN=1 (MEM_DEPTH=256) -> beat 0 written, beat 1 dropped; BRESP=11.
- AWBURST=11 with AWLEN=0, followed by an early-WLAST INCR burst -> no memory change on the first; both return BRESP=10. BREADY held low 5 cycles -> BVALID/BID/BRESP stable.
- Reset asserted in the middle of the beats of an AWLEN=7 burst -> no BVALID; AWREADY=1 on the first cycle after reset deasserts; a new burst completes with OKAY.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types and defaults for the AXI write-side slave.
// The optional WID check is enabled with the AXI_WID_CHECK_EN macro.
package axi_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SIZE  = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address and burst legality for one AXI burst.
// Illegal bursts hold the address so every beat stays at the start address.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE  = DEF_SIZE,
    parameter int LEN_W = WIDTH / 8
) (
    input  logic [WIDTH-1:0] addr,
    input  logic [SIZE-1:0]  size,
    input  logic [LEN_W-1:0] len,
    input  logic [SIZE-2:0]  burst,
    output logic [WIDTH-1:0] next_addr,
    output logic             illegal
);

    localparam int LANE_SH = $clog2(WIDTH / 8);

    logic [WIDTH-1:0] nbytes;
    logic [WIDTH-1:0] wrap_mask;
    logic [WIDTH-1:0] incr_addr;
    logic             is_wrap;
    logic             len_ok;

    always_comb begin
        nbytes    = WIDTH'(1) << size;
        wrap_mask = ((WIDTH'(len) + WIDTH'(1)) << size) - WIDTH'(1);
        incr_addr = addr + nbytes;
        is_wrap   = (burst == (SIZE-1)'(BURST_WRAP));
        len_ok    = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                    (len == LEN_W'(7)) || (len == LEN_W'(15));
        illegal   = (burst == (SIZE-1)'(BURST_RSVD)) ||
                    (size > SIZE'(LANE_SH)) ||
                    (is_wrap && (!len_ok || ((addr & (nbytes - WIDTH'(1))) != '0)));

        next_addr = addr;
        if (!illegal) begin
            if (burst == (SIZE-1)'(BURST_INCR)) begin
                next_addr = incr_addr;
            end else if (is_wrap) begin
                // Legal wrap windows are powers of two, so masking keeps beats inside the window.
                next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            end
        end
    end

endmodule

// File: rtl/axi_slave_write_ctrl.sv
// AXI write slave: one burst at a time into a byte-strobed word memory, one B per burst.
// Define AXI_WID_CHECK_EN to drop and flag beats whose WID differs from the latched AWID.
module axi_slave_write_ctrl
    import axi_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SIZE      = DEF_SIZE,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [WIDTH-1:0]             AWADDR,
    input  logic [WIDTH/8-1:0]           AWID,
    input  logic [WIDTH/8-1:0]           AWLEN,
    input  logic [SIZE-1:0]              AWSIZE,
    input  logic [SIZE-2:0]              AWBURST,
    input  logic                         WVALID,
    output logic                         WREADY,
    input  logic [WIDTH-1:0]             WDATA,
    input  logic [WIDTH/8-1:0]           WSTRB,
    input  logic                         WLAST,
    input  logic [WIDTH/8-1:0]           WID,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic [WIDTH/8-1:0]           BID,
    output logic [SIZE-2:0]              BRESP,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [WIDTH-1:0]             dbg_rdata
);

    localparam int ID_W    = WIDTH / 8;
    localparam int NLANE   = WIDTH / 8;
    localparam int AW_W    = $clog2(MEM_DEPTH);
    localparam int LANE_SH = $clog2(WIDTH / 8);

    state_e           state;
    logic [WIDTH-1:0] mem [MEM_DEPTH];
    logic [WIDTH-1:0] cur_addr;
    logic [WIDTH-1:0] next_addr;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  cur_len;
    logic [ID_W-1:0]  beat_cnt;
    logic [SIZE-1:0]  cur_size;
    logic [SIZE-2:0]  cur_burst;
    logic             slverr;
    logic             decerr;
    logic             illegal;
    logic             aw_hs;
    logic             beat_hs;
    logic             in_range;
    logic             last_beat;
    logic             wid_ok;
    logic             mem_we;
    logic             slverr_nxt;
    logic             decerr_nxt;
    logic [AW_W-1:0]  word_idx;

    axi_burst_addr_gen #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE),
        .LEN_W (ID_W)
    ) u_addr_gen (
        .addr      (cur_addr),
        .size      (cur_size),
        .len       (cur_len),
        .burst     (cur_burst),
        .next_addr (next_addr),
        .illegal   (illegal)
    );

`ifdef AXI_WID_CHECK_EN
    assign wid_ok = (WID == cur_id);
`else
    logic unused_wid;
    assign unused_wid = ^WID;
    assign wid_ok     = 1'b1;
`endif

    always_comb begin
        aw_hs      = (state == ST_IDLE) && AWVALID && AWREADY;
        beat_hs    = (state == ST_DATA) && WVALID && WREADY;
        in_range   = (cur_addr >> (AW_W + LANE_SH)) == '0;
        word_idx   = cur_addr[AW_W+LANE_SH-1:LANE_SH];
        last_beat  = (beat_cnt == cur_len);
        mem_we     = beat_hs && !reset && !illegal && in_range && wid_ok;
        slverr_nxt = slverr || illegal || (WLAST != last_beat) || !wid_ok;
        decerr_nxt = decerr || !in_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BID      <= '0;
            BRESP    <= '0;
            beat_cnt <= '0;
            slverr   <= 1'b0;
            decerr   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b1;
                        beat_cnt <= '0;
                        slverr   <= 1'b0;
                        decerr   <= 1'b0;
                        state    <= ST_DATA;
                    end else begin
                        AWREADY  <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (beat_hs) begin
                        beat_cnt <= beat_cnt + ID_W'(1);
                        slverr   <= slverr_nxt;
                        decerr   <= decerr_nxt;
                        // The burst ends on the beat count; WLAST only feeds the error flag.
                        if (last_beat) begin
                            WREADY <= 1'b0;
                            BVALID <= 1'b1;
                            BID    <= cur_id;
                            BRESP  <= decerr_nxt ? (SIZE-1)'(RESP_DECERR) :
                                      slverr_nxt ? (SIZE-1)'(RESP_SLVERR) :
                                                   (SIZE-1)'(RESP_OKAY);
                            state  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            cur_addr  <= AWADDR;
            cur_id    <= AWID;
            cur_len   <= AWLEN;
            cur_size  <= AWSIZE;
            cur_burst <= AWBURST;
        end else if (beat_hs) begin
            cur_addr  <= next_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NLANE; b++) begin
                if (WSTRB[b]) begin
                    mem[word_idx][8*b +: 8] <= WDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rdata <= '0;
        end else begin
            dbg_rdata <= mem[dbg_addr];
        end
    end

endmodule
